// File: rtl/enigma_pkg.sv
// Shared types and helpers for the rotor step controller: states, letter arithmetic, lamp check.
// Pure declarations; no timing or flow control of its own.
package enigma_pkg;

  localparam int LETTERS = 26;

  typedef logic [4:0] letter_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STEP_HI,
    ST_STEP_LO,
    ST_SETTLE,
    ST_OUTPUT,
    ST_ALIGN_HI,
    ST_ALIGN_LO
  } state_e;

  typedef struct packed {
    letter_t ring;
    letter_t notch;
  } wiring_config_t;

  // Historical rotor III/II/I in the right/middle/left slots; notch letters V, E, Q.
  localparam wiring_config_t WIRING_R = '{ring: 5'd0, notch: 5'd21};
  localparam wiring_config_t WIRING_M = '{ring: 5'd0, notch: 5'd4};
  localparam wiring_config_t WIRING_L = '{ring: 5'd0, notch: 5'd16};

  function automatic letter_t inc26(input letter_t v);
    return (v == letter_t'(LETTERS - 1)) ? '0 : v + 5'd1;
  endfunction

  // Forward distance from 'from' to 'to' around the 26-letter ring.
  function automatic letter_t dist26(input letter_t from, input letter_t to);
    logic [5:0] d;
    d = {1'b0, to} + 6'(LETTERS) - {1'b0, from};
    if (d >= 6'(LETTERS)) d = d - 6'(LETTERS);
    return d[4:0];
  endfunction

  function automatic logic is_onehot26(input logic [25:0] v);
    logic [4:0] cnt;
    cnt = '0;
    for (int i = 0; i < 26; i++) cnt = cnt + {4'd0, v[i]};
    return cnt == 5'd1;
  endfunction

endpackage

// File: rtl/enigma_pos_tracker.sv
// One rotor's tracked position and outstanding alignment steps.
// Updates on the clock edge after inc/dec/load; no backpressure.
module enigma_pos_tracker
  import enigma_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       inc_i,
  input  logic       dec_i,
  input  logic       load_i,
  input  logic [4:0] rem_i,
  output logic [4:0] pos_o,
  output logic [4:0] rem_o
);

  letter_t pos_q, pos_d;
  letter_t rem_q, rem_d;

  always_comb begin
    pos_d = pos_q;
    rem_d = rem_q;
    if (load_i) begin
      rem_d = rem_i;
    end else if (dec_i && rem_q != 5'd0) begin
      rem_d = rem_q - 5'd1;
    end
    if (inc_i) pos_d = inc26(pos_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_q <= '0;
      rem_q <= '0;
    end else begin
      pos_q <= pos_d;
      rem_q <= rem_d;
    end
  end

  assign pos_o = pos_q;
  assign rem_o = rem_q;

endmodule

// File: rtl/enigma_step_controller.sv
// Steps three rotors per keypress (with double-step), captures the lamp after settling, aligns on request.
// Key to cipher_valid is 3+SETTLE_CYCLES cycles; result held until cipher_ready, keys accepted only when idle.
module enigma_step_controller
  import enigma_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int NUM_LETTERS   = 26
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_valid,
  input  logic [25:0] key_onehot,
  output logic        key_ready,
  input  logic        align_valid,
  input  logic [14:0] align_pos,
  output logic        align_err,
  output logic        rotate_r,
  output logic        rotate_m,
  output logic        rotate_l,
  input  logic        notch_r,
  input  logic        notch_m,
  output logic [25:0] rotor_in,
  input  logic [25:0] lamp_in,
  output logic        cipher_valid,
  output logic [25:0] cipher_onehot,
  input  logic        cipher_ready,
  output logic        cipher_err,
  output logic [4:0]  pos_r,
  output logic [4:0]  pos_m,
  output logic [4:0]  pos_l
);

  state_e      state_q, state_d;
  logic [25:0] key_q, key_d;
  logic [25:0] cipher_q, cipher_d;
  logic [2:0]  rot_q, rot_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        cerr_q, cerr_d;
  logic        aerr_q, aerr_d;

  logic        align_ok;
  logic        load;
  logic [4:0]  rem_r, rem_m, rem_l;
  logic [4:0]  new_r, new_m, new_l;
  logic [2:0]  rem_nz, new_nz, inc, dec;

  localparam logic [4:0] MAX_LETTER = 5'(NUM_LETTERS - 1);

  assign align_ok = (align_pos[4:0] <= MAX_LETTER) && (align_pos[9:5] <= MAX_LETTER)
                 && (align_pos[14:10] <= MAX_LETTER);
  assign new_r  = dist26(pos_r, align_pos[4:0]);
  assign new_m  = dist26(pos_m, align_pos[9:5]);
  assign new_l  = dist26(pos_l, align_pos[14:10]);
  assign new_nz = {new_l != 5'd0, new_m != 5'd0, new_r != 5'd0};
  assign rem_nz = {rem_l != 5'd0, rem_m != 5'd0, rem_r != 5'd0};

  // Positions advance while the matching strobe is high; align steps also burn remaining count.
  assign inc = rot_q & {3{state_q == ST_STEP_HI || state_q == ST_ALIGN_HI}};
  assign dec = rot_q & {3{state_q == ST_ALIGN_HI}};

  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    cipher_d = cipher_q;
    rot_d    = 3'b000;
    cnt_d    = cnt_q;
    cerr_d   = cerr_q;
    aerr_d   = 1'b0;
    load     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (align_valid) begin
          if (!align_ok) begin
            aerr_d = 1'b1;
          end else begin
            load = 1'b1;
            if (|new_nz) begin
              rot_d   = new_nz;
              state_d = ST_ALIGN_HI;
            end
          end
        end else if (key_valid) begin
          key_d   = key_onehot;
          rot_d   = {notch_m, notch_r | notch_m, 1'b1};
          state_d = ST_STEP_HI;
        end
      end
      ST_STEP_HI: state_d = ST_STEP_LO;
      ST_STEP_LO: begin
        cnt_d   = 4'(SETTLE_CYCLES - 1);
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == 4'd0) begin
          cipher_d = lamp_in;
          cerr_d   = !is_onehot26(lamp_in);
          state_d  = ST_OUTPUT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_OUTPUT: if (cipher_ready) state_d = ST_IDLE;
      ST_ALIGN_HI: state_d = ST_ALIGN_LO;
      ST_ALIGN_LO: begin
        if (|rem_nz) begin
          rot_d   = rem_nz;
          state_d = ST_ALIGN_HI;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      key_q    <= '0;
      cipher_q <= '0;
      rot_q    <= '0;
      cnt_q    <= '0;
      cerr_q   <= 1'b0;
      aerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      cipher_q <= cipher_d;
      rot_q    <= rot_d;
      cnt_q    <= cnt_d;
      cerr_q   <= cerr_d;
      aerr_q   <= aerr_d;
    end
  end

  enigma_pos_tracker u_trk_r (
    .clk(clk), .reset(reset), .inc_i(inc[0]), .dec_i(dec[0]), .load_i(load),
    .rem_i(new_r), .pos_o(pos_r), .rem_o(rem_r)
  );
  enigma_pos_tracker u_trk_m (
    .clk(clk), .reset(reset), .inc_i(inc[1]), .dec_i(dec[1]), .load_i(load),
    .rem_i(new_m), .pos_o(pos_m), .rem_o(rem_m)
  );
  enigma_pos_tracker u_trk_l (
    .clk(clk), .reset(reset), .inc_i(inc[2]), .dec_i(dec[2]), .load_i(load),
    .rem_i(new_l), .pos_o(pos_l), .rem_o(rem_l)
  );

  assign key_ready     = (state_q == ST_IDLE);
  assign cipher_valid  = (state_q == ST_OUTPUT);
  assign rotor_in      = (state_q == ST_SETTLE || state_q == ST_OUTPUT) ? key_q : '0;
  assign cipher_onehot = cipher_q;
  assign cipher_err    = cerr_q;
  assign align_err     = aerr_q;
  assign rotate_r      = rot_q[0];
  assign rotate_m      = rot_q[1];
  assign rotate_l      = rot_q[2];

endmodule

// File: tb/tb_enigma_step_controller.sv
// Randomized bench for the step controller against a ring-arithmetic position model and strobe counters.
module tb_enigma_step_controller;

  localparam int SETTLE = 4;

  logic        clk, reset;
  logic        key_valid, key_ready;
  logic [25:0] key_onehot;
  logic        align_valid, align_err;
  logic [14:0] align_pos;
  logic        rotate_r, rotate_m, rotate_l;
  logic        notch_r, notch_m;
  logic [25:0] rotor_in, lamp_in, cipher_onehot;
  logic        cipher_valid, cipher_ready, cipher_err;
  logic [4:0]  pos_r, pos_m, pos_l;

  int checks = 0;
  int errors = 0;
  int mpos[3];                 // model positions: 0 = right, 1 = middle, 2 = left
  int scnt[3] = '{0, 0, 0};    // observed strobe pulses per rotor
  int viol = 0;                // strobes seen high on two consecutive samples
  logic [2:0] rot_prev = 3'b000;

  enigma_step_controller #(.SETTLE_CYCLES(SETTLE), .NUM_LETTERS(26)) dut (
    .clk(clk), .reset(reset),
    .key_valid(key_valid), .key_onehot(key_onehot), .key_ready(key_ready),
    .align_valid(align_valid), .align_pos(align_pos), .align_err(align_err),
    .rotate_r(rotate_r), .rotate_m(rotate_m), .rotate_l(rotate_l),
    .notch_r(notch_r), .notch_m(notch_m),
    .rotor_in(rotor_in), .lamp_in(lamp_in),
    .cipher_valid(cipher_valid), .cipher_onehot(cipher_onehot),
    .cipher_ready(cipher_ready), .cipher_err(cipher_err),
    .pos_r(pos_r), .pos_m(pos_m), .pos_l(pos_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scrambler stand-in: notches sit at right = 22, middle = 5.
  assign notch_r = (mpos[0] == 22);
  assign notch_m = (mpos[1] == 5);

  always @(negedge clk) begin
    logic [2:0] now;
    now = {rotate_l, rotate_m, rotate_r};
    for (int i = 0; i < 3; i++) begin
      if (now[i] && !rot_prev[i]) scnt[i]++;
      if (now[i] && rot_prev[i]) viol++;
    end
    rot_prev = now;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_pos();
    chk("pos_lmr", {17'd0, pos_l, pos_m, pos_r}, {17'd0, 5'(mpos[2]), 5'(mpos[1]), 5'(mpos[0])});
  endtask

  task automatic chk_reset_outputs();
    chk("rst_key_ready", key_ready, 1);
    chk("rst_strobes", {rotate_l, rotate_m, rotate_r}, 0);
    chk("rst_rotor_in", rotor_in, 0);
    chk("rst_flags", {cipher_valid, cipher_err, align_err}, 0);
    chk("rst_cipher_onehot", cipher_onehot, 0);
    chk("rst_pos", {pos_l, pos_m, pos_r}, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mpos = '{0, 0, 0};
    @(negedge clk);
  endtask

  task automatic do_key(input logic [25:0] key, input logic [25:0] lamp, input int hold);
    int n;
    int s[3];
    bit st_m, st_l;
    chk("key_ready_idle", key_ready, 1);
    chk("rotor_in_idle", rotor_in, 0);
    s    = scnt;
    st_m = (mpos[0] == 22) || (mpos[1] == 5);
    st_l = (mpos[1] == 5);
    lamp_in = lamp; key_onehot = key; key_valid = 1'b1; cipher_ready = 1'b0;
    @(negedge clk);
    key_valid = 1'b0;
    n = 1;
    while (!cipher_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("key_latency", n, 3 + SETTLE);
    chk("cipher_onehot", cipher_onehot, lamp);
    chk("cipher_err", cipher_err, ($countones(lamp) != 1));
    chk("rotor_in_settled", rotor_in, key);
    for (int i = 0; i < hold; i++) begin
      key_valid  = 1'b1;
      key_onehot = 26'd1 << $urandom_range(0, 25);
      lamp_in    = ~lamp;
      @(negedge clk);
      chk("hold_valid", cipher_valid, 1);
      chk("hold_onehot", cipher_onehot, lamp);
      chk("hold_err", cipher_err, ($countones(lamp) != 1));
      chk("hold_key_ready", key_ready, 0);
    end
    key_valid = 1'b0; cipher_ready = 1'b1;
    @(negedge clk);
    cipher_ready = 1'b0;
    chk("release_valid", cipher_valid, 0);
    chk("release_key_ready", key_ready, 1);
    mpos[0] = (mpos[0] + 1) % 26;
    if (st_m) mpos[1] = (mpos[1] + 1) % 26;
    if (st_l) mpos[2] = (mpos[2] + 1) % 26;
    chk("key_strobe_r", scnt[0] - s[0], 1);
    chk("key_strobe_m", scnt[1] - s[1], st_m);
    chk("key_strobe_l", scnt[2] - s[2], st_l);
    chk_pos();
  endtask

  task automatic do_align(input logic [14:0] ap);
    int n, mx;
    int t[3];
    int rem[3];
    int s[3];
    bit bad;
    chk("align_ready_idle", key_ready, 1);
    s    = scnt;
    t[0] = int'(ap[4:0]);
    t[1] = int'(ap[9:5]);
    t[2] = int'(ap[14:10]);
    bad  = (t[0] > 25) || (t[1] > 25) || (t[2] > 25);
    mx   = 0;
    for (int i = 0; i < 3; i++) begin
      rem[i] = bad ? 0 : (t[i] - mpos[i] + 26) % 26;
      if (rem[i] > mx) mx = rem[i];
    end
    align_pos = ap; align_valid = 1'b1;
    key_valid = 1'($urandom_range(0, 1)); key_onehot = 26'd1;
    @(negedge clk);
    align_valid = 1'b0; key_valid = 1'b0;
    n = 1;
    chk("align_err", align_err, bad);
    while (!key_ready && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk("align_cycles", n, 2 * mx + 1);
    @(negedge clk);
    chk("align_err_clear", align_err, 0);
    chk("align_strobe_r", scnt[0] - s[0], rem[0]);
    chk("align_strobe_m", scnt[1] - s[1], rem[1]);
    chk("align_strobe_l", scnt[2] - s[2], rem[2]);
    if (!bad) for (int i = 0; i < 3; i++) mpos[i] = t[i];
    chk_pos();
  endtask

  initial begin
    logic [14:0] ap;
    logic [25:0] lmp;
    reset = 1'b1; key_valid = 1'b0; key_onehot = '0; align_valid = 1'b0;
    align_pos = '0; cipher_ready = 1'b0; lamp_in = '0;
    mpos = '{0, 0, 0};
    repeat (2) @(negedge clk);
    chk_reset_outputs();
    reset = 1'b0;
    @(negedge clk);

    do_key(26'd1, 26'd1 << 7, 0);
    do_reset();
    do_align({5'd3, 5'd25, 5'd24});
    do_align({5'd3, 5'd25, 5'd24});
    do_align({5'd3, 5'd25, 5'd27});
    do_align({5'd0, 5'd4, 5'd22});
    do_key(26'd1 << 4, 26'd1 << 11, 0);
    do_key(26'd1 << 9, 26'd1 << 2, 1);
    do_key(26'd1, 26'h3, 10);

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        ap = {5'($urandom_range(0, 27)), 5'($urandom_range(0, 27)), 5'($urandom_range(0, 27))};
        do_align(ap);
      end else begin
        lmp = ($urandom_range(0, 4) == 0) ? 26'($urandom) : (26'd1 << $urandom_range(0, 25));
        do_key(26'd1 << $urandom_range(0, 25), lmp, $urandom_range(0, 3));
      end
    end

    do_align({5'd7, 5'd8, 5'd9});
    lamp_in = 26'd1; key_onehot = 26'd1 << 3; key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_reset_rotor_in", rotor_in, 26'd1 << 3);
    reset = 1'b1;
    #1;
    chk_reset_outputs();
    @(negedge clk);
    reset = 1'b0;
    mpos = '{0, 0, 0};
    @(negedge clk);
    do_key(26'd1 << 5, 26'd1 << 6, 0);

    chk("strobe_width", viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/enigma_step_controller.md
Name: enigma_step_controller

Overview:
- Sequences the three-rotor scrambler (right, middle, left rotor instances) for one keypress at a time.
- Per keypress:
  - Issues the `rotate` strobes, including the double-step.
  - Waits for the combinational rotor/reflector chain to settle.
  - Captures the lamp one-hot and hands it downstream with a valid/ready handshake.
- Also aligns the rotors to a requested start position (rotors have no load or reset) by issuing repeated `rotate` strobes from its tracked positions.

Parameters:
- SETTLE_CYCLES, 4, cycles between strobe falling edge and lamp capture (1..15).
- NUM_LETTERS, 26, alphabet size; fixed, used for mod arithmetic.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- key_valid  in  1  keypress request.
- key_onehot  in  26  pressed letter, one-hot, bit0 = A.
- key_ready  out  1  controller idle and accepting a key or alignment.
- align_valid  in  1  alignment request.
- align_pos  in  15  target positions {left[14:10], mid[9:5], right[4:0]}, each 0..25.
- align_err  out  1  one-cycle pulse: align request rejected.
- rotate_r, rotate_m, rotate_l  out  1 each  rotor step strobes; rotor advances on rising edge.
- notch_r, notch_m  in  1 each  turnover notch from the right and middle rotors.
- rotor_in  out  26  one-hot driven into the scrambler chain.
- lamp_in  in  26  one-hot returned from the scrambler chain.
- cipher_valid  out  1  cipher result available.
- cipher_onehot  out  26  captured lamp value.
- cipher_ready  in  1  downstream accepts the result.
- cipher_err  out  1  qualifies cipher_valid: the captured lamp value was not one-hot.
- pos_r, pos_m, pos_l  out  5 each  tracked rotor positions, 0..25.

Behaviour:
- Reset:
  - State IDLE, key_ready = 1.
  - All rotate strobes 0, rotor_in = 0, cipher_valid = 0, cipher_onehot = 0, cipher_err = 0, align_err = 0.
  - pos_r/m/l = 0, matching the rotor power-on position A.
- Reset mid-operation aborts immediately. Rotors that already stepped are not tracked back; re-alignment is software's job.
- Strobes are registered and glitch-free. Every strobe pulse is high exactly 1 cycle, then low at least 1 cycle.
- States:
  - IDLE
  - STEP_HI: strobes high
  - STEP_LO: strobes low
  - SETTLE: counter from SETTLE_CYCLES-1 down to 0
  - OUTPUT: cipher_valid held
  - ALIGN_HI, ALIGN_LO
- IDLE, simultaneous requests: if both key_valid and align_valid are high, align wins. key_ready stays high; the key is simply not accepted that cycle.
- IDLE, key accept (key_valid & key_ready):
  - Latch key_onehot.
  - Sample notch_r, notch_m. Compute:
    - step_r = 1
    - step_m = notch_r | notch_m
    - step_l = notch_m
  - Go to STEP_HI.
- STEP_HI:
  - Assert the selected strobes.
  - Increment the corresponding pos_* mod 26 (25 -> 0).
  - Next STEP_LO.
- STEP_LO: strobes 0. Next SETTLE.
- SETTLE and OUTPUT: rotor_in = latched key; rotor_in = 0 in every other state.
- SETTLE exit, counter = 0:
  - Register lamp_in into cipher_onehot.
  - cipher_err = (popcount(lamp_in) != 1).
  - Go to OUTPUT.
- Key latency: key accept to cipher_valid = 3 + SETTLE_CYCLES cycles.
- OUTPUT:
  - cipher_valid = 1; cipher_onehot and cipher_err stay stable until cipher_valid & cipher_ready.
  - On that handshake, return to IDLE with cipher_valid = 0 on the next cycle.
  - A new key can be accepted only from IDLE; no overlap.
- IDLE, align accept:
  - If any 5-bit field is > 25: pulse align_err for 1 cycle and stay in IDLE, with no strobes and no position change.
  - Otherwise latch per-rotor remaining = (target - pos + 26) mod 26.
  - If all remaining = 0: return to IDLE next cycle.
  - Else go to ALIGN_HI.
- ALIGN_HI:
  - Strobe each rotor whose remaining != 0.
  - Increment its pos mod 26 and decrement its remaining.
  - Next ALIGN_LO.
- ALIGN_LO:
  - Strobes low.
  - If all remaining = 0, go to IDLE; else go to ALIGN_HI.
- Align duration: at most 25 iterations, 50 cycles plus 1. Notches are ignored during alignment.
- key_ready = 1 only in IDLE.

Decomposition:
- Package enigma_pkg holds:
  - state enum
  - LETTERS = 26
  - letter index typedef (5-bit)
  - a mod-26 increment function
  - a popcount/one-hot check function
  - rotor wiring_config constants shared with the rotor block
- One natural sub-module: enigma_pos_tracker. It holds one rotor's position and remaining count, with inc/load/decrement. Instantiated three times.

Test Plan:
- Reset, then key A with notches 0, SETTLE_CYCLES = 4:
  - rotate_r pulses once; rotate_m and rotate_l stay 0.
  - pos = 0/0/1.
  - cipher_valid rises 7 cycles after accept, holding the bench lamp_in value.
- Double-step: bench notch model asserts notch_r at pos_r = 22, and notch_m at pos_m = 5 with pos_r = 23 after the first key.
  - First key: right and middle step.
  - Next key: all three step. pos_l increments once, pos_m goes 5 -> 6.
- Align to {l = 3, m = 25, r = 24} from 0/0/0:
  - rotate_l 3 pulses, rotate_m 25, rotate_r 24.
  - Ends after 25 HI/LO iterations with pos = 3/25/24.
  - Repeating the same align issues 0 strobes.
- Align with the right field = 27: align_err pulses 1 cycle, no strobes, pos unchanged.
- Backpressure and lamp check:
  - Hold cipher_ready = 0 for 10 cycles: cipher_onehot stable and key_ready = 0 throughout; key_valid ignored.
  - lamp_in = 26'h3 gives cipher_err = 1.
- Assert reset during SETTLE: all outputs return to reset values in the same cycle, pos = 0/0/0.
